// File: rtl/ae_sensor_reg_writer.sv
// Turns AE exposure/gain results into a group-held burst of six sensor register writes
// for the I2C master, with change suppression, coalescing of late updates and a done timeout.
module ae_sensor_reg_writer #(
    parameter logic [15:0] EXP_REG_H   = 16'h3501,
    parameter logic [15:0] EXP_REG_L   = 16'h3502,
    parameter logic [15:0] GAIN_REG_H  = 16'h350A,
    parameter logic [15:0] GAIN_REG_L  = 16'h350B,
    parameter logic [15:0] HOLD_REG    = 16'h3208,
    parameter logic [7:0]  HOLD_START  = 8'h00,
    parameter logic [7:0]  HOLD_LAUNCH = 8'hA0,
    parameter int          TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        post_valid,
    input  logic [15:0] exposure_time,
    input  logic [15:0] exposure_gain,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    output logic        busy,
    output logic [15:0] update_cnt,
    output logic        timeout_err,
    output logic [1:0]  state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [2:0]    step, step_d;
    logic [15:0]   work_exp, work_exp_d, work_gain, work_gain_d;
    logic [15:0]   last_exp, last_exp_d, last_gain, last_gain_d;
    logic [15:0]   pend_exp, pend_exp_d, pend_gain, pend_gain_d;
    logic          pend_v, pend_v_d;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic          wr_valid_d;
    logic [15:0]   wr_addr_d;
    logic [7:0]    wr_data_d;
    logic [15:0]   update_cnt_d;
    logic          timeout_err_d;
    logic [15:0]   cand_exp, cand_gain;
    logic [15:0]   step_addr;
    logic [7:0]    step_data;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        step_addr = HOLD_REG;
        step_data = HOLD_LAUNCH;
        case (step)
            3'd0: begin step_addr = HOLD_REG;   step_data = HOLD_START;       end
            3'd1: begin step_addr = EXP_REG_H;  step_data = work_exp[15:8];   end
            3'd2: begin step_addr = EXP_REG_L;  step_data = work_exp[7:0];    end
            3'd3: begin step_addr = GAIN_REG_H; step_data = work_gain[15:8];  end
            3'd4: begin step_addr = GAIN_REG_L; step_data = work_gain[7:0];   end
            default: begin step_addr = HOLD_REG; step_data = HOLD_LAUNCH;     end
        endcase
    end

    // Handshake: a command transfers on the cycle wr_valid & wr_ready are both high; until
    // then wr_valid, wr_addr and wr_data are held. wr_done later marks that command finished.
    always_comb begin
        state_d       = state;
        step_d        = step;
        work_exp_d    = work_exp;
        work_gain_d   = work_gain;
        last_exp_d    = last_exp;
        last_gain_d   = last_gain;
        pend_exp_d    = pend_exp;
        pend_gain_d   = pend_gain;
        pend_v_d      = pend_v;
        tmo_cnt_d     = tmo_cnt;
        wr_valid_d    = wr_valid;
        wr_addr_d     = wr_addr;
        wr_data_d     = wr_data;
        update_cnt_d  = update_cnt;
        timeout_err_d = 1'b0;
        cand_exp      = pend_v ? pend_exp  : exposure_time;
        cand_gain     = pend_v ? pend_gain : exposure_gain;

        case (state)
            IDLE: begin
                if (pend_v || post_valid) begin
                    pend_v_d = 1'b0;
                    if ({cand_exp, cand_gain} != {last_exp, last_gain}) begin
                        work_exp_d  = cand_exp;
                        work_gain_d = cand_gain;
                        step_d      = 3'd0;
                        state_d     = ISSUE;
                    end
                    // A fresh pair arriving while the stored one is consumed stays queued.
                    if (pend_v && post_valid) begin
                        pend_exp_d  = exposure_time;
                        pend_gain_d = exposure_gain;
                        pend_v_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (wr_valid && wr_ready) begin
                    wr_valid_d = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_DONE;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = step_addr;
                    wr_data_d  = step_data;
                end
            end
            WAIT_DONE: begin
                if (wr_done) begin
                    if (step == 3'd5) begin
                        last_exp_d   = work_exp;
                        last_gain_d  = work_gain;
                        update_cnt_d = update_cnt + 16'd1;
                        state_d      = IDLE;
                    end else begin
                        step_d  = step + 3'd1;
                        state_d = ISSUE;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Forget the last values so the next pair rewrites every register.
                    timeout_err_d = 1'b1;
                    last_exp_d    = 16'hFFFF;
                    last_gain_d   = 16'hFFFF;
                    state_d       = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state != IDLE && post_valid) begin
            pend_exp_d  = exposure_time;
            pend_gain_d = exposure_gain;
            pend_v_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            step        <= 3'd0;
            work_exp    <= 16'h0000;
            work_gain   <= 16'h0000;
            last_exp    <= 16'hFFFF;
            last_gain   <= 16'hFFFF;
            pend_exp    <= 16'h0000;
            pend_gain   <= 16'h0000;
            pend_v      <= 1'b0;
            tmo_cnt     <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= 16'h0000;
            wr_data     <= 8'h00;
            update_cnt  <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            step        <= step_d;
            work_exp    <= work_exp_d;
            work_gain   <= work_gain_d;
            last_exp    <= last_exp_d;
            last_gain   <= last_gain_d;
            pend_exp    <= pend_exp_d;
            pend_gain   <= pend_gain_d;
            pend_v      <= pend_v_d;
            tmo_cnt     <= tmo_cnt_d;
            wr_valid    <= wr_valid_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            update_cnt  <= update_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
endmodule
